// File: rtl/phy_tx_lane_serializer.sv
// phy_tx_lane_serializer: merges LANES parallel byte lanes round-robin onto a
// single MSB-first serial bitstream clocked at the bit rate. After reset it
// sends COM_COUNT COM symbols, then enters RUN. In RUN, each symbol slot carries
// the owning lane's held word, or IDLE_SYM when that lane has nothing pending.
// Optional build macro: PHY_TX_PARITY_EN appends one even-parity bit per
// symbol, which makes the symbol period WIDTH+1 clocks.
module phy_tx_lane_serializer #(
  parameter int unsigned      LANES     = 4,
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] COM_SYM   = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE_SYM  = 8'h7C,
  parameter int unsigned      COM_COUNT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES*WIDTH-1:0]     data_in,
  input  logic [LANES-1:0]           valid_in,
  output logic [LANES-1:0]           ready_out,
  output logic                       serial_out,
  output logic                       sym_strobe,
  output logic [$clog2(LANES)-1:0]   lane_sel,
  output logic                       active
);

  localparam int unsigned LANE_W = $clog2(LANES);
`ifdef PHY_TX_PARITY_EN
  localparam int unsigned PERIOD = WIDTH + 1;
`else
  localparam int unsigned PERIOD = WIDTH;
`endif
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned COM_W  = $clog2(COM_COUNT + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(PERIOD - 1);
  localparam logic [COM_W-1:0]  COM_LAST  = COM_W'(COM_COUNT);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_RST = 2'd0,
    ST_COM = 2'd1,
    ST_RUN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [COM_W-1:0]    com_cnt_q, com_cnt_d;
  logic [LANE_W-1:0]   slot_q, slot_d;
  logic [LANE_W-1:0]   lane_sel_q, lane_sel_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic                serial_q, serial_d;
  logic                strobe_q, strobe_d;
  logic [LANES-1:0]    hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0]    hold_data_q [LANES];
  logic [WIDTH-1:0]    hold_data_d [LANES];
`ifdef PHY_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic                boundary;
  logic                com_done;
  logic                run_load;
  logic [WIDTH-1:0]    sym_next;
  logic [LANES-1:0]    drain;
  logic [LANES-1:0]    accept;

  // The first edge after reset release, and every last-bit edge, starts a new symbol.
  always_comb begin
    boundary = (state_q == ST_RST) || (bit_cnt_q == LAST_BIT);
    com_done = (com_cnt_q == COM_LAST);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: RST -> COM at once; COM -> RUN at the boundary after the last COM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_COM;
      ST_COM:  if (boundary && com_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RST;
    endcase
  end

  // FSM outputs: lane readiness mirrors the empty hold registers outside RST
  always_comb begin
    active    = (state_q == ST_RUN);
    ready_out = (state_q == ST_RST) ? '0 : ~hold_valid_q;
  end

  // Symbol selection at a boundary: COM during the preamble, else lane data or IDLE
  always_comb begin
    sym_next = COM_SYM;
    drain    = '0;
    run_load = boundary && (state_d == ST_RUN);
    if (run_load) begin
      if (hold_valid_q[slot_q]) begin
        sym_next        = hold_data_q[slot_q];
        drain[slot_q]   = 1'b1;
      end else begin
        sym_next = IDLE_SYM;
      end
    end
  end

  // Hold-register next state: accepted words fill, the serviced lane drains
  always_comb begin
    accept       = valid_in & ready_out;
    hold_valid_d = (hold_valid_q & ~drain) | accept;
    for (int unsigned i = 0; i < LANES; i++) begin
      hold_data_d[i] = accept[i] ? data_in[i*WIDTH +: WIDTH] : hold_data_q[i];
    end
  end

  // Counters, slot pointer and shifter next state
  always_comb begin
    bit_cnt_d  = boundary ? '0 : bit_cnt_q + CNT_W'(1);
    strobe_d   = boundary;
    com_cnt_d  = com_cnt_q;
    slot_d     = slot_q;
    lane_sel_d = lane_sel_q;
    shift_d    = shift_q << 1;
    serial_d   = shift_q[WIDTH-1];
`ifdef PHY_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (boundary && (state_d == ST_COM)) begin
      com_cnt_d = com_cnt_q + COM_W'(1);
    end
    if (run_load) begin
      lane_sel_d = slot_q;
      slot_d     = (slot_q == LAST_LANE) ? '0 : slot_q + LANE_W'(1);
    end
    if (boundary) begin
      serial_d = sym_next[WIDTH-1];
      shift_d  = sym_next << 1;
`ifdef PHY_TX_PARITY_EN
      parity_d = ^sym_next;
`endif
    end
`ifdef PHY_TX_PARITY_EN
    else if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
      serial_d = parity_q;
    end
`endif
  end

  // Datapath registers; reset aborts any symbol in flight and empties all lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q    <= '0;
      com_cnt_q    <= '0;
      slot_q       <= '0;
      lane_sel_q   <= '0;
      shift_q      <= '0;
      serial_q     <= 1'b0;
      strobe_q     <= 1'b0;
      hold_valid_q <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        hold_data_q[i] <= '0;
      end
`ifdef PHY_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      com_cnt_q    <= com_cnt_d;
      slot_q       <= slot_d;
      lane_sel_q   <= lane_sel_d;
      shift_q      <= shift_d;
      serial_q     <= serial_d;
      strobe_q     <= strobe_d;
      hold_valid_q <= hold_valid_d;
      for (int unsigned i = 0; i < LANES; i++) begin
        hold_data_q[i] <= hold_data_d[i];
      end
`ifdef PHY_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Registered outputs
  always_comb begin
    serial_out = serial_q;
    sym_strobe = strobe_q;
    lane_sel   = lane_sel_q;
  end

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Scoreboard bench for phy_tx_lane_serializer (default parameters). The stimulus
// pushes the hand-derived expected symbols. A monitor deserialises every strobed
// symbol and pops the matching entry. Define PHY_TX_PARITY_EN to check the
// parity build.
module tb_phy_tx_lane_serializer;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
`ifdef PHY_TX_PARITY_EN
  localparam int PER = WIDTH + 1;
`else
  localparam int PER = WIDTH;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  valid_in = '0;
  logic [3:0]  ready_out;
  logic        serial_out;
  logic        sym_strobe;
  logic [1:0]  lane_sel;
  logic        active;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] sym;
    logic [1:0] lane;
    logic       act;
  } exp_t;

  exp_t sb[$];

  phy_tx_lane_serializer #(
    .LANES(LANES), .WIDTH(WIDTH), .COM_SYM(8'hBC), .IDLE_SYM(8'h7C), .COM_COUNT(4)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .serial_out(serial_out), .sym_strobe(sym_strobe),
    .lane_sel(lane_sel), .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] s, input logic [1:0] l, input logic a);
    exp_t e;
    e.sym = s; e.lane = l; e.act = a;
    sb.push_back(e);
  endtask

  task automatic push_com();
    for (int i = 0; i < 4; i++) push(8'hBC, 2'd0, 1'b0);
  endtask

  task automatic reset_assert();
    @(negedge clk);
    reset = 1'b0;
    valid_in = '0;
    #1 chk("reset_outputs", {27'd0, serial_out, sym_strobe, active, lane_sel, ready_out} , 32'd0);
    repeat (2) @(negedge clk);
    sb.delete();
  endtask

  task automatic reset_release();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 3000 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL %s_drain: %0d expected symbols never seen", name, sb.size());
      sb.delete();
    end
  endtask

  // Offer a word on one lane until it is taken; reports strobe/lane_sel in the accept cycle.
  task automatic send(input int lane, input logic [7:0] d, output logic stb, output logic [1:0] ls);
    bit ok;
    ok = 1'b0; stb = 1'b0; ls = '0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      data_in[lane*8 +: 8] = d;
      valid_in[lane] = 1'b1;
      ok  = ready_out[lane];
      stb = sym_strobe;
      ls  = lane_sel;
      @(posedge clk);
    end
    #1 valid_in[lane] = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: lane %0d data %0h not accepted", lane, d);
    end
  endtask

  task automatic wait_slot(input logic [1:0] l, output logic [3:0] prev_rdy);
    logic [3:0] pr;
    bit found;
    found = 1'b0;
    pr = ready_out;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk);
      if (sym_strobe && active && lane_sel == l) found = 1'b1;
      else pr = ready_out;
    end
    prev_rdy = pr;
    if (!found) begin
      checks++; errors++;
      $display("FAIL slot_timeout: lane %0d slot never came", l);
    end
  endtask

  // Monitor: deserialise each strobed symbol and compare it with the scoreboard head
  initial begin : monitor
    logic [7:0] got;
    logic [1:0] ls;
    logic       act;
    logic       midstb;
    logic       par;
    bit         aborted;
    exp_t       e;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && sym_strobe && sb.size() > 0) begin
        got = '0;
        got[7] = serial_out;
        ls = lane_sel;
        act = active;
        midstb = 1'b0;
        aborted = 1'b0;
        for (int b = 6; b >= 0; b--) begin
          @(negedge clk);
          if (!reset) begin aborted = 1'b1; break; end
          got[b] = serial_out;
          if (sym_strobe) midstb = 1'b1;
        end
`ifdef PHY_TX_PARITY_EN
        if (!aborted) begin
          @(negedge clk);
          if (!reset) aborted = 1'b1;
          else begin
            par = serial_out;
            if (sym_strobe) midstb = 1'b1;
          end
        end
`endif
        if (!aborted && sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (got !== e.sym || ls !== e.lane || act !== e.act || midstb) begin
            errors++;
            $display("FAIL symbol: got sym=%0h lane=%0d active=%0b midstrobe=%0b expected sym=%0h lane=%0d active=%0b",
                     got, ls, act, midstb, e.sym, e.lane, e.act);
          end
`ifdef PHY_TX_PARITY_EN
          // BC and 7C each hold five ones, so both carry parity 1; A5 carries 0.
          checks++;
          if (par !== ^e.sym) begin
            errors++;
            $display("FAIL parity: sym %0h got parity %0b expected %0b", e.sym, par, ^e.sym);
          end
`endif
        end
      end
    end
  end

  initial begin : stimulus
    logic       stb;
    logic [1:0] ls;
    logic [3:0] pr;
    int         cnt [4];

    // 1: preamble then one IDLE round
    reset_assert();
    push_com();
    push(8'h7C, 2'd0, 1'b1); push(8'h7C, 2'd1, 1'b1);
    push(8'h7C, 2'd2, 1'b1); push(8'h7C, 2'd3, 1'b1);
    push(8'h7C, 2'd0, 1'b1);
    reset_release();
    wait_drain("preamble");

    // 2: single word on lane 2 during COM
    reset_assert();
    push_com();
    push(8'h7C, 2'd0, 1'b1); push(8'h7C, 2'd1, 1'b1);
    push(8'hA5, 2'd2, 1'b1); push(8'h7C, 2'd3, 1'b1);
    reset_release();
    repeat (2) @(negedge clk);
    send(2, 8'hA5, stb, ls);
    chk("single_ready_drop", {31'd0, ready_out[2]}, 32'd0);
    wait_slot(2'd2, pr);
    chk("single_ready_before_load", {31'd0, pr[2]}, 32'd0);
    chk("single_ready_after_load", {31'd0, ready_out[2]}, 32'd1);
    wait_drain("single");

    // 3: all lanes streaming continuously
    reset_assert();
    push_com();
    for (int r = 0; r < 2; r++) begin
      push(8'h11, 2'd0, 1'b1); push(8'h22, 2'd1, 1'b1);
      push(8'h33, 2'd2, 1'b1); push(8'h44, 2'd3, 1'b1);
    end
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    reset_release();
    valid_in = 4'hF;
    wait_drain("full");
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int n = 0; n < LANES*PER; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (ready_out[i]) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("full_ready_once_lane%0d", i), cnt[i], 32'd1);
    valid_in = '0;

    // 4: back-to-back words on lane 1
    reset_assert();
    push_com();
    push(8'h7C, 2'd0, 1'b1); push(8'h01, 2'd1, 1'b1);
    push(8'h7C, 2'd2, 1'b1); push(8'h7C, 2'd3, 1'b1);
    push(8'h7C, 2'd0, 1'b1); push(8'h02, 2'd1, 1'b1);
    reset_release();
    repeat (2) @(negedge clk);
    send(1, 8'h01, stb, ls);
    send(1, 8'h02, stb, ls);
    chk("b2b_accept_after_load", {29'd0, stb, ls}, {29'd0, 1'b1, 2'd1});
    wait_drain("b2b");

    // 5: reset in the middle of a data symbol, with lane 2 still holding a word
    reset_assert();
    push_com();
    reset_release();
    repeat (2) @(negedge clk);
    send(0, 8'h5A, stb, ls);
    send(2, 8'h96, stb, ls);
    wait_drain("midreset_pre");
    wait_slot(2'd0, pr);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("midreset_outputs", {27'd0, serial_out, sym_strobe, active, lane_sel, ready_out}, 32'd0);
    repeat (2) @(negedge clk);
    sb.delete();
    push_com();
    push(8'h7C, 2'd0, 1'b1); push(8'h7C, 2'd1, 1'b1);
    push(8'h7C, 2'd2, 1'b1); push(8'h7C, 2'd3, 1'b1);
    reset_release();
    wait_drain("midreset_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
